// File: rtl/cache_direct.sv
// Direct-mapped, write-back, write-allocate data cache.
// It sits between the pipeline's MEM stage and a slower line-oriented backing memory.
// A miss stalls the CPU with cpu_ready=0. The cache then writes back a dirty victim
// if there is one, and fills the line from backing memory.
module cache_direct #(
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              cpu_addr,
    input  logic [31:0]              cpu_data_in,
    input  logic                     cpu_enable,
    input  logic                     cpu_read_write,
    input  logic [3:0]               cpu_byte_enable,
    output logic [31:0]              cpu_data_out,
    output logic                     cpu_ready,
    output logic [31:0]              mem_addr,
    output logic                     mem_enable,
    output logic                     mem_read_write,
    output logic [32*LINE_WORDS-1:0] mem_data_out,
    input  logic [32*LINE_WORDS-1:0] mem_data_in,
    input  logic                     mem_ack
);

    localparam int WO  = $clog2(LINE_WORDS);
    localparam int IW  = $clog2(LINES);
    localparam int OFF = WO + 2;
    localparam int TW  = 32 - OFF - IW;
    localparam int LW  = 32 * LINE_WORDS;

    typedef enum logic [1:0] {COMPARE, WRITEBACK, ALLOCATE} state_t;

    state_t state, next_state;

    logic [LINES-1:0] valid;
    logic [LINES-1:0] dirty;
    logic [TW-1:0]    tags  [LINES];
    logic [LW-1:0]    lines [LINES];

    // The line being serviced is latched at the miss.
    // This lets a request that is withdrawn mid-miss still fill the right line.
    logic [IW-1:0] miss_idx;
    logic [TW-1:0] miss_tag;

    logic [WO-1:0] word_off;
    logic [IW-1:0] idx;
    logic [TW-1:0] req_tag;
    logic          hit;
    logic          write_hit;
    logic [LW-1:0] cur_line;
    logic [31:0]   cur_word;
    logic [31:0]   merged_word;
    logic [LW-1:0] new_line;

    assign word_off  = cpu_addr[OFF-1:2];
    assign idx       = cpu_addr[OFF+IW-1:OFF];
    assign req_tag   = cpu_addr[31:OFF+IW];
    assign hit       = cpu_enable && valid[idx] && (tags[idx] == req_tag);
    assign write_hit = (state == COMPARE) && hit && !cpu_read_write;
    assign cur_line  = lines[idx];
    assign cur_word  = cur_line[{word_off, 5'b0} +: 32];

    // Merge the enabled store byte lanes into the addressed word.
    // The merged word is then placed back into its line.
    always_comb begin
        merged_word = cur_word;
        for (int b = 0; b < 4; b++) begin
            if (cpu_byte_enable[b]) begin
                merged_word[8*b +: 8] = cpu_data_in[8*b +: 8];
            end
        end
        new_line = cur_line;
        new_line[{word_off, 5'b0} +: 32] = merged_word;
    end

    // Next-state logic and all CPU/memory-side outputs.
    // Memory-side outputs are forced idle while reset is asserted.
    always_comb begin
        next_state     = state;
        cpu_ready      = 1'b0;
        cpu_data_out   = 32'h0;
        mem_enable     = 1'b0;
        mem_read_write = 1'b1;
        mem_addr       = 32'h0;
        mem_data_out   = '0;
        case (state)
            COMPARE: begin
                cpu_ready = !cpu_enable || hit;
                if (hit && cpu_read_write) begin
                    cpu_data_out = cur_word;
                end
                if (cpu_enable && !hit) begin
                    next_state = (valid[idx] && dirty[idx]) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                cpu_ready      = !cpu_enable;
                mem_enable     = 1'b1;
                mem_read_write = 1'b0;
                mem_addr       = {tags[miss_idx], miss_idx, {OFF{1'b0}}};
                mem_data_out   = lines[miss_idx];
                if (mem_ack) begin
                    next_state = ALLOCATE;
                end
            end
            ALLOCATE: begin
                cpu_ready      = !cpu_enable;
                mem_enable     = 1'b1;
                mem_read_write = 1'b1;
                mem_addr       = {miss_tag, miss_idx, {OFF{1'b0}}};
                if (mem_ack) begin
                    next_state = COMPARE;
                end
            end
            default: begin
                next_state = COMPARE;
            end
        endcase
        if (reset) begin
            mem_enable     = 1'b0;
            mem_read_write = 1'b1;
            mem_addr       = 32'h0;
            mem_data_out   = '0;
        end
    end

    // State register. Reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= COMPARE;
        end else begin
            state <= next_state;
        end
    end

    // Capture the index and tag of the request that missed.
    always_ff @(posedge clk) begin
        if (!reset && state == COMPARE && cpu_enable && !hit) begin
            miss_idx <= idx;
            miss_tag <= req_tag;
        end
    end

    // Maintain the valid and dirty bits through hits, write-backs and fills.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
            dirty <= '0;
        end else begin
            if (write_hit) begin
                dirty[idx] <= 1'b1;
            end
            if (state == WRITEBACK && mem_ack) begin
                dirty[miss_idx] <= 1'b0;
            end
            if (state == ALLOCATE && mem_ack) begin
                valid[miss_idx] <= 1'b1;
                dirty[miss_idx] <= 1'b0;
            end
        end
    end

    // Data and tag storage. Not cleared by reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (write_hit) begin
                lines[idx] <= new_line;
            end else if (state == ALLOCATE && mem_ack) begin
                lines[miss_idx] <= mem_data_in;
                tags[miss_idx]  <= miss_tag;
            end
        end
    end

endmodule

// File: tb/tb_cache_direct.sv
// Directed testbench for cache_direct with the default geometry.
// Geometry is 16 lines of 4 words: word [3:2], index [7:4], tag [31:8].
// Inputs change at the falling edge; outputs are sampled 1ns later.
module tb_cache_direct;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_data_in;
    logic         cpu_enable;
    logic         cpu_read_write;
    logic [3:0]   cpu_byte_enable;
    logic [31:0]  cpu_data_out;
    logic         cpu_ready;
    logic [31:0]  mem_addr;
    logic         mem_enable;
    logic         mem_read_write;
    logic [127:0] mem_data_out;
    logic [127:0] mem_data_in;
    logic         mem_ack;

    int total = 0;
    int bad   = 0;

    cache_direct #(.LINES(16), .LINE_WORDS(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .cpu_addr        (cpu_addr),
        .cpu_data_in     (cpu_data_in),
        .cpu_enable      (cpu_enable),
        .cpu_read_write  (cpu_read_write),
        .cpu_byte_enable (cpu_byte_enable),
        .cpu_data_out    (cpu_data_out),
        .cpu_ready       (cpu_ready),
        .mem_addr        (mem_addr),
        .mem_enable      (mem_enable),
        .mem_read_write  (mem_read_write),
        .mem_data_out    (mem_data_out),
        .mem_data_in     (mem_data_in),
        .mem_ack         (mem_ack)
    );

    always #5 clk = ~clk;

    // Drive a CPU read request.
    task automatic cpu_read(input logic [31:0] a);
        cpu_addr = a; cpu_enable = 1'b1; cpu_read_write = 1'b1; cpu_byte_enable = 4'b0000;
    endtask

    // Drive a CPU write request.
    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        cpu_addr = a; cpu_data_in = d; cpu_enable = 1'b1; cpu_read_write = 1'b0; cpu_byte_enable = be;
    endtask

    task automatic test_reset();
        reset = 1'b1; cpu_enable = 1'b0; cpu_addr = 32'h0; cpu_data_in = 32'h0;
        cpu_read_write = 1'b1; cpu_byte_enable = 4'b0; mem_ack = 1'b0; mem_data_in = '0;
        @(negedge clk); @(negedge clk); #1;
        total++; if (cpu_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready: got %0h want 1", cpu_ready); end
        total++; if (mem_enable !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_enable: got %0h want 0", mem_enable); end
        total++; if (mem_read_write !== 1'b1) begin bad++; $display("[TB] FAIL reset_mem_rw: got %0h want 1", mem_read_write); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("[TB] FAIL reset_mem_addr: got %h want 0", mem_addr); end
        total++; if (mem_data_out !== 128'h0) begin bad++; $display("[TB] FAIL reset_mem_data: got %h want 0", mem_data_out); end
        reset = 1'b0;
    endtask

    task automatic test_cold_miss();
        @(negedge clk); cpu_read(32'h10); #1;
        total++; if (cpu_ready !== 1'b0) begin bad++; $display("[TB] FAIL cold_stall: got %0h want 0", cpu_ready); end
        @(negedge clk); #1;
        total++; if (mem_enable !== 1'b1) begin bad++; $display("[TB] FAIL cold_mem_enable: got %0h want 1", mem_enable); end
        total++; if (mem_read_write !== 1'b1) begin bad++; $display("[TB] FAIL cold_mem_rw: got %0h want 1", mem_read_write); end
        total++; if (mem_addr !== 32'h10) begin bad++; $display("[TB] FAIL cold_mem_addr: got %h want 10", mem_addr); end
        total++; if (cpu_ready !== 1'b0) begin bad++; $display("[TB] FAIL cold_stall2: got %0h want 0", cpu_ready); end
        @(negedge clk);
        @(negedge clk);
        mem_ack = 1'b1; mem_data_in = {32'hA3, 32'h12345678, 32'hA1, 32'hA0};
        @(negedge clk); mem_ack = 1'b0; #1;
        total++; if (cpu_ready !== 1'b1) begin bad++; $display("[TB] FAIL cold_ready: got %0h want 1", cpu_ready); end
        total++; if (cpu_data_out !== 32'hA0) begin bad++; $display("[TB] FAIL cold_data: got %h want a0", cpu_data_out); end
        total++; if (mem_enable !== 1'b0) begin bad++; $display("[TB] FAIL cold_mem_idle: got %0h want 0", mem_enable); end
    endtask

    task automatic test_read_hit();
        @(negedge clk); cpu_read(32'h14); #1;
        total++; if (cpu_ready !== 1'b1) begin bad++; $display("[TB] FAIL hit_ready: got %0h want 1", cpu_ready); end
        total++; if (cpu_data_out !== 32'hA1) begin bad++; $display("[TB] FAIL hit_data: got %h want a1", cpu_data_out); end
        total++; if (mem_enable !== 1'b0) begin bad++; $display("[TB] FAIL hit_mem_idle: got %0h want 0", mem_enable); end
        @(negedge clk); cpu_read(32'h18); #1;
        total++; if (cpu_data_out !== 32'h12345678) begin bad++; $display("[TB] FAIL hit_word2: got %h want 12345678", cpu_data_out); end
        // A stray ack while idle must not start or disturb anything.
        @(negedge clk); cpu_enable = 1'b0; mem_ack = 1'b1; #1;
        total++; if (cpu_data_out !== 32'h0) begin bad++; $display("[TB] FAIL idle_data_zero: got %h want 0", cpu_data_out); end
        @(negedge clk); mem_ack = 1'b0; #1;
        total++; if (mem_enable !== 1'b0) begin bad++; $display("[TB] FAIL stray_ack_idle: got %0h want 0", mem_enable); end
        @(negedge clk); cpu_read(32'h14); #1;
        total++; if (cpu_ready !== 1'b1 || cpu_data_out !== 32'hA1) begin bad++; $display("[TB] FAIL stray_ack_hit: got ready=%0h data=%h want 1/a1", cpu_ready, cpu_data_out); end
    endtask

    task automatic test_partial_write();
        @(negedge clk); cpu_write(32'h18, 32'hAAAABBBB, 4'b0011); #1;
        total++; if (cpu_ready !== 1'b1) begin bad++; $display("[TB] FAIL pw_ready: got %0h want 1", cpu_ready); end
        total++; if (cpu_data_out !== 32'h0) begin bad++; $display("[TB] FAIL pw_data_zero: got %h want 0", cpu_data_out); end
        @(negedge clk); cpu_read(32'h18); #1;
        total++; if (cpu_data_out !== 32'h1234BBBB) begin bad++; $display("[TB] FAIL pw_merge: got %h want 1234bbbb", cpu_data_out); end
        @(negedge clk); cpu_read(32'h1C); #1;
        total++; if (cpu_data_out !== 32'hA3) begin bad++; $display("[TB] FAIL pw_neighbour: got %h want a3", cpu_data_out); end
    endtask

    task automatic test_dirty_eviction();
        @(negedge clk); cpu_read(32'h118); #1;
        total++; if (cpu_ready !== 1'b0) begin bad++; $display("[TB] FAIL ev_stall: got %0h want 0", cpu_ready); end
        @(negedge clk); #1;
        total++; if (mem_enable !== 1'b1 || mem_read_write !== 1'b0) begin bad++; $display("[TB] FAIL ev_wb_cmd: got en=%0h rw=%0h want 1/0", mem_enable, mem_read_write); end
        total++; if (mem_addr !== 32'h10) begin bad++; $display("[TB] FAIL ev_wb_addr: got %h want 10", mem_addr); end
        total++; if (mem_data_out[95:64] !== 32'h1234BBBB) begin bad++; $display("[TB] FAIL ev_wb_word2: got %h want 1234bbbb", mem_data_out[95:64]); end
        total++; if (mem_data_out[31:0] !== 32'hA0) begin bad++; $display("[TB] FAIL ev_wb_word0: got %h want a0", mem_data_out[31:0]); end
        mem_ack = 1'b1; mem_data_in = '0;
        @(negedge clk); mem_ack = 1'b0; #1;
        total++; if (mem_enable !== 1'b1 || mem_read_write !== 1'b1) begin bad++; $display("[TB] FAIL ev_alloc_cmd: got en=%0h rw=%0h want 1/1", mem_enable, mem_read_write); end
        total++; if (mem_addr !== 32'h110) begin bad++; $display("[TB] FAIL ev_alloc_addr: got %h want 110", mem_addr); end
        mem_ack = 1'b1; mem_data_in = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
        @(negedge clk); mem_ack = 1'b0; #1;
        total++; if (cpu_ready !== 1'b1 || cpu_data_out !== 32'hB2) begin bad++; $display("[TB] FAIL ev_hit: got ready=%0h data=%h want 1/b2", cpu_ready, cpu_data_out); end
    endtask

    task automatic test_reset_mid_allocate();
        @(negedge clk); cpu_read(32'h14); #1;
        total++; if (cpu_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_miss: got %0h want 0", cpu_ready); end
        @(negedge clk); #1;
        total++; if (mem_enable !== 1'b1 || mem_read_write !== 1'b1 || mem_addr !== 32'h10) begin bad++; $display("[TB] FAIL rst_clean_alloc: got en=%0h rw=%0h addr=%h want 1/1/10", mem_enable, mem_read_write, mem_addr); end
        reset = 1'b1; cpu_enable = 1'b0;
        @(negedge clk); reset = 1'b0; #1;
        total++; if (mem_enable !== 1'b0) begin bad++; $display("[TB] FAIL rst_abort: got %0h want 0", mem_enable); end
        @(negedge clk); cpu_read(32'h114); #1;
        total++; if (cpu_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_invalidated: got %0h want 0", cpu_ready); end
        @(negedge clk); #1;
        total++; if (mem_enable !== 1'b1 || mem_read_write !== 1'b1 || mem_addr !== 32'h110) begin bad++; $display("[TB] FAIL rst_refill: got en=%0h rw=%0h addr=%h want 1/1/110", mem_enable, mem_read_write, mem_addr); end
        mem_ack = 1'b1; mem_data_in = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
        @(negedge clk); mem_ack = 1'b0; #1;
        total++; if (cpu_ready !== 1'b1 || cpu_data_out !== 32'hC1) begin bad++; $display("[TB] FAIL rst_refill_hit: got ready=%0h data=%h want 1/c1", cpu_ready, cpu_data_out); end
    endtask

    task automatic test_enable_drop();
        @(negedge clk); cpu_read(32'h24); #1;
        total++; if (cpu_ready !== 1'b0) begin bad++; $display("[TB] FAIL drop_miss: got %0h want 0", cpu_ready); end
        @(negedge clk); #1;
        total++; if (mem_enable !== 1'b1 || mem_addr !== 32'h20) begin bad++; $display("[TB] FAIL drop_alloc: got en=%0h addr=%h want 1/20", mem_enable, mem_addr); end
        cpu_enable = 1'b0; cpu_addr = 32'h300; #1;
        total++; if (cpu_ready !== 1'b1 || cpu_data_out !== 32'h0) begin bad++; $display("[TB] FAIL drop_ready: got ready=%0h data=%h want 1/0", cpu_ready, cpu_data_out); end
        @(negedge clk); mem_ack = 1'b1; mem_data_in = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        @(negedge clk); mem_ack = 1'b0; #1;
        total++; if (mem_enable !== 1'b0) begin bad++; $display("[TB] FAIL drop_done: got %0h want 0", mem_enable); end
        @(negedge clk); cpu_read(32'h28); #1;
        total++; if (cpu_ready !== 1'b1 || cpu_data_out !== 32'hD2 || mem_enable !== 1'b0) begin bad++; $display("[TB] FAIL drop_hit: got ready=%0h data=%h en=%0h want 1/d2/0", cpu_ready, cpu_data_out, mem_enable); end
    endtask

    task automatic test_write_miss();
        @(negedge clk); cpu_write(32'h34, 32'hCAFEF00D, 4'b1111); #1;
        total++; if (cpu_ready !== 1'b0) begin bad++; $display("[TB] FAIL wm_stall: got %0h want 0", cpu_ready); end
        @(negedge clk); #1;
        total++; if (mem_enable !== 1'b1 || mem_read_write !== 1'b1 || mem_addr !== 32'h30) begin bad++; $display("[TB] FAIL wm_alloc: got en=%0h rw=%0h addr=%h want 1/1/30", mem_enable, mem_read_write, mem_addr); end
        mem_ack = 1'b1; mem_data_in = {32'hE3, 32'hE2, 32'hE1, 32'hE0};
        @(negedge clk); mem_ack = 1'b0; #1;
        total++; if (cpu_ready !== 1'b1) begin bad++; $display("[TB] FAIL wm_ready: got %0h want 1", cpu_ready); end
        @(negedge clk); cpu_read(32'h34); #1;
        total++; if (cpu_data_out !== 32'hCAFEF00D) begin bad++; $display("[TB] FAIL wm_data: got %h want cafef00d", cpu_data_out); end
        @(negedge clk); cpu_read(32'h134); #1;
        total++; if (cpu_ready !== 1'b0) begin bad++; $display("[TB] FAIL wm_evict_stall: got %0h want 0", cpu_ready); end
        @(negedge clk); #1;
        total++; if (mem_read_write !== 1'b0 || mem_addr !== 32'h30 || mem_data_out[63:32] !== 32'hCAFEF00D) begin bad++; $display("[TB] FAIL wm_dirty_wb: got rw=%0h addr=%h w1=%h want 0/30/cafef00d", mem_read_write, mem_addr, mem_data_out[63:32]); end
        mem_ack = 1'b1;
        @(negedge clk); mem_ack = 1'b0; #1;
        total++; if (mem_read_write !== 1'b1 || mem_addr !== 32'h130) begin bad++; $display("[TB] FAIL wm_realloc: got rw=%0h addr=%h want 1/130", mem_read_write, mem_addr); end
        mem_ack = 1'b1;
        @(negedge clk); mem_ack = 1'b0; cpu_enable = 1'b0;
    endtask

    initial begin
        $display("[TB] starting cache_direct directed tests");
        test_reset();
        test_cold_miss();
        test_read_hit();
        test_partial_write();
        test_dirty_eviction();
        test_reset_mid_allocate();
        test_enable_drop();
        test_write_miss();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
